e1_tx_hdb3_enc: RTL and testbench
=================================

// Module: e1_tx_hdb3_enc
// PURPOSE
//  E1 transmit line encoder, directly downstream of the TX framer. Consumes the
//  framer's serial NRZ bitstream (one bit per in_valid strobe) and produces
//  HDB3- or AMI-coded bipolar output pulses on out_p/out_n for the LIU
//  driver, per G.703.
//  Pulse width is fixed in clk cycles.
// PARAMETERS
//  PULSE_W  7  Pulse width in clk cycles; 1..(min in_valid spacing - 1).
// PORTS
//  clk          in   1   clock
//  rst          in   1   reset, asynchronous, active-high
//  in_bit       in   1   NRZ data bit from framer
//  in_valid     in   1   one-cycle bit strobe (framer bit rate)
//  ctrl_hdb3    in   1   1=HDB3 substitution, 0=plain AMI
//  ctrl_ais     in   1   1=replace input with all-ones (AIS)
//  ctrl_tx_en   in   1   0=force out_p/out_n low (encoder keeps running)
//  out_p        out  1   positive pulse drive
//  out_n        out  1   negative pulse drive
//  out_sym_stb  out  1   one-cycle strobe per emitted symbol
// BEHAVIOUR
//  Reset values:
//  - out_p=0, out_n=0, out_sym_stb=0.
//  - Symbol pipeline all ZERO, last_pol=NEG (so the first pulse is POS),
//    parity=0, pulse counter=0.
//  Symbol codes (2 b): 00 ZERO, 01 MARK, 10 B, 11 V. Pipeline sym[3:0], with
//  sym[3] the oldest.
//  On each in_valid (all in one clk edge):
//  - Pop: sym[3] goes to the output stage.
//    - MARK/B: pol = ~last_pol; last_pol <= pol.
//    - V: pol = last_pol (same polarity as the previous pulse).
//    - ZERO: no pulse; last_pol unchanged.
//  - Push: d = ctrl_ais | in_bit. Shift sym[2:0]->sym[3:1], sym[0] = d ? MARK : ZERO.
//    A MARK toggles parity.
//  - Substitute: if ctrl_hdb3 and the post-push sym[3:0] are all ZERO:
//    - parity=1: sym[0]=V (000V).
//    - parity=0: sym[3]=B, sym[0]=V (B00V).
//    - parity <= 0 in both cases.
//    - Slots already holding V/B never match, so no overlapping re-detection.
//  - Latency: a bit's symbol leaves the encoder on the 4th in_valid after it
//    was pushed (fixed 4-bit delay, AMI included).
//  Output stage:
//  - Cycle after in_valid: out_sym_stb=1 for one cycle.
//  - If the popped symbol is non-ZERO, the pulse counter loads PULSE_W and
//    out_p (pol=POS) or out_n (pol=NEG) is high while the counter is nonzero,
//    i.e. for exactly PULSE_W cycles.
//  - out_p and out_n are never high simultaneously.
//  - A new in_valid during an active pulse truncates it; the new symbol
//    takes over. This is a configuration error but must stay glitch-safe.
//  - ctrl_tx_en=0 gates out_p/out_n to 0 combinationally after the register;
//    pipeline, parity and polarity continue updating.
//  Boundary conditions:
//  - ctrl_hdb3 / ctrl_ais changes are sampled only at in_valid and apply to
//    the bit being pushed; pipeline contents are kept. Leaving HDB3 with V/B
//    in the pipeline emits them normally.
//  - No in_valid: state frozen, outputs idle after the pulse ends.
//  - rst asserted mid-pulse clears outputs immediately (async).
//  - Arithmetic: pulse counter is $clog2(PULSE_W+1) bits, saturating-down at 0.
// CONFIGURATION
//  E1_TX_HDB3_VCNT_EN defined:
//  - Adds output vcnt[15:0]: count of V symbols emitted.
//  - Saturates at 16'hffff, reset 0, increments on the out_sym_stb cycle of a V.
//  E1_TX_HDB3_VCNT_EN undefined:
//  - No vcnt port and no counter logic. Encoding is identical either way.
// TESTING
//  - Reset, then in_bit=1 x6 (AMI or HDB3): pulses alternate P,N,P,N,... The
//    first pulse comes on the 4th strobe after the first bit, which follows
//    the 4 zeros loaded at reset. Each pulse is exactly PULSE_W cycles.
//  - HDB3, bits 1,0,0,0,0 after an odd pulse count since the last V:
//    - Line shows +,0,0,0,+ (000V; V equals the last polarity).
//    - Then bit 1 gives '-'.
//  - HDB3, bits 1,1,0,0,0,0 after the last V (parity even): line shows
//    +,-,+(B),0,0,+(V).
//  - Continuous zeros, HDB3:
//    - Steady repeating B00V: B and V alternate polarity pairwise and DC
//      balance holds (P count == N count over 64 bits).
//    - AMI: no pulses at all.
//  - ctrl_ais=1 with in_bit=0 gives an all-MARK alternating stream.
//  - ctrl_tx_en=0 keeps out_p/out_n=0, but re-enabling continues the correct
//    polarity sequence.
//  - Async rst pulse mid-stream clears outputs within the same cycle; the next
//    mark after reset is POS. With VCNT_EN, vcnt is 0 after reset and counts
//    the V symbols from the zeros test.

Source files
------------

// File: rtl/e1_tx_hdb3_enc.sv
// E1 transmit line encoder: 4-symbol HDB3/AMI substitution pipeline feeding a fixed-width pulser.
// Optional V-symbol counter output (vcnt) is built when E1_TX_HDB3_VCNT_EN is defined.
module e1_tx_hdb3_enc #(
  parameter int unsigned PULSE_W = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_bit,
  input  logic        in_valid,
  input  logic        ctrl_hdb3,
  input  logic        ctrl_ais,
  input  logic        ctrl_tx_en,
  output logic        out_p,
  output logic        out_n,
`ifdef E1_TX_HDB3_VCNT_EN
  output logic [15:0] vcnt,
`endif
  output logic        out_sym_stb
);

  localparam int unsigned CntW = $clog2(PULSE_W + 1);

  typedef enum logic [1:0] {
    SymZero = 2'b00,
    SymMark = 2'b01,
    SymB    = 2'b10,
    SymV    = 2'b11
  } sym_e;

  localparam logic PolPos = 1'b1;
  localparam logic PolNeg = 1'b0;

  // sym_q[3] is the oldest symbol and the next one to leave the encoder.
  sym_e            sym_q [4];
  sym_e            sym_d [4];
  logic            last_pol_q, last_pol_d;
  logic            parity_q, parity_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pol_q, pol_d;
  logic            stb_q;
  logic            p_q, n_q;

  logic            data;
  logic            all_zero;
  logic            pop_pulse;
  logic            pulse_pol;

  // Pop, push and substitution all resolve within the strobe cycle.
  always_comb begin
    sym_d      = sym_q;
    last_pol_d = last_pol_q;
    parity_d   = parity_q;
    pop_pulse  = 1'b0;
    pulse_pol  = pol_q;
    all_zero   = 1'b0;
    data       = ctrl_ais | in_bit;

    if (in_valid) begin
      case (sym_q[3])
        SymMark, SymB: begin
          pop_pulse  = 1'b1;
          pulse_pol  = ~last_pol_q;
          last_pol_d = ~last_pol_q;
        end
        SymV: begin
          pop_pulse = 1'b1;
          pulse_pol = last_pol_q;
        end
        default: begin
          pop_pulse = 1'b0;
        end
      endcase

      sym_d[3] = sym_q[2];
      sym_d[2] = sym_q[1];
      sym_d[1] = sym_q[0];
      if (data) begin
        sym_d[0] = SymMark;
      end else begin
        sym_d[0] = SymZero;
      end
      parity_d = parity_q ^ data;

      all_zero = (sym_d[3] == SymZero) && (sym_d[2] == SymZero) &&
                 (sym_d[1] == SymZero) && (sym_d[0] == SymZero);

      // All-zero window implies data=0, so parity_q is the mark parity since the last V.
      if (ctrl_hdb3 && all_zero) begin
        if (!parity_q) begin
          sym_d[3] = SymB;
        end
        sym_d[0] = SymV;
        parity_d = 1'b0;
      end
    end
  end

  // A strobe always restarts the pulser, truncating any pulse still in flight.
  always_comb begin
    cnt_d = cnt_q;
    pol_d = pol_q;
    if (in_valid) begin
      cnt_d = pop_pulse ? CntW'(PULSE_W) : '0;
      pol_d = pulse_pol;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym_q      <= '{default: SymZero};
      last_pol_q <= PolNeg;
      parity_q   <= 1'b0;
      cnt_q      <= '0;
      pol_q      <= PolNeg;
      stb_q      <= 1'b0;
      p_q        <= 1'b0;
      n_q        <= 1'b0;
    end else begin
      sym_q      <= sym_d;
      last_pol_q <= last_pol_d;
      parity_q   <= parity_d;
      cnt_q      <= cnt_d;
      pol_q      <= pol_d;
      stb_q      <= in_valid;
      p_q        <= (cnt_d != '0) && (pol_d == PolPos);
      n_q        <= (cnt_d != '0) && (pol_d == PolNeg);
    end
  end

  assign out_p       = p_q & ctrl_tx_en;
  assign out_n       = n_q & ctrl_tx_en;
  assign out_sym_stb = stb_q;

`ifdef E1_TX_HDB3_VCNT_EN
  logic        v_q;
  logic [15:0] vcnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q    <= 1'b0;
      vcnt_q <= 16'h0000;
    end else begin
      v_q <= in_valid && (sym_q[3] == SymV);
      if (stb_q && v_q && (vcnt_q != 16'hffff)) begin
        vcnt_q <= vcnt_q + 16'd1;
      end
    end
  end

  assign vcnt = vcnt_q;
`endif

  a_no_overlap: assert property (@(posedge clk) disable iff (rst) !(out_p && out_n));

endmodule

// File: tb/tb_e1_tx_hdb3_enc.sv
// Bench for e1_tx_hdb3_enc: directed vector table, hand-written corner sequences and
// randomized strobes checked against a queue-based HDB3 stream model.
module tb_e1_tx_hdb3_enc;

  localparam int unsigned PulseW = 7;
  localparam int unsigned Gap    = 10;
  localparam int NumVec = 49;

  localparam int SZero = 0;
  localparam int SMark = 1;
  localparam int SB    = 2;
  localparam int SV    = 3;
  localparam int LNone = 0;
  localparam int LPos  = 1;
  localparam int LNeg  = 2;

  logic clk, rst, in_bit, in_valid, ctrl_hdb3, ctrl_ais, ctrl_tx_en;
  logic out_p, out_n, out_sym_stb;
`ifdef E1_TX_HDB3_VCNT_EN
  logic [15:0] vcnt;
`endif

  e1_tx_hdb3_enc #(
    .PULSE_W(PulseW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_bit     (in_bit),
    .in_valid   (in_valid),
    .ctrl_hdb3  (ctrl_hdb3),
    .ctrl_ais   (ctrl_ais),
    .ctrl_tx_en (ctrl_tx_en),
    .out_p      (out_p),
    .out_n      (out_n),
`ifdef E1_TX_HDB3_VCNT_EN
    .vcnt       (vcnt),
`endif
    .out_sym_stb(out_sym_stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp   = 0;
  int n_fail  = 0;
  int overlap = 0;

  always @(negedge clk) begin
    if (out_p && out_n) overlap++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: the line is a stream of symbols; 4 reset zeros precede the first pushed bit.
  int m_q[$];
  bit m_parity;
  bit m_last_pos;
  int m_vcount;

  function automatic void model_reset();
    m_q.delete();
    for (int i = 0; i < 4; i++) m_q.push_back(SZero);
    m_parity   = 1'b0;
    m_last_pos = 1'b0;
    m_vcount   = 0;
  endfunction

  function automatic int model_step(input bit b, input bit hdb3, input bit ais);
    int s;
    int code;
    bit d;
    s    = m_q.pop_front();
    code = LNone;
    if (s == SMark || s == SB) begin
      m_last_pos = ~m_last_pos;
      code       = m_last_pos ? LPos : LNeg;
    end else if (s == SV) begin
      code = m_last_pos ? LPos : LNeg;
      m_vcount++;
    end
    d = b | ais;
    m_q.push_back(d ? SMark : SZero);
    if (d) m_parity = ~m_parity;
    if (hdb3 && m_q[0] == SZero && m_q[1] == SZero && m_q[2] == SZero && m_q[3] == SZero) begin
      if (!m_parity) m_q[0] = SB;
      m_q[3]   = SV;
      m_parity = 1'b0;
    end
    return code;
  endfunction

  // One strobe, then Gap samples on the falling edges that follow it.
  task automatic strobe(input bit b, input bit hdb3, input bit ais, input bit en,
                        output logic [Gap-1:0] tp, output logic [Gap-1:0] tn,
                        output logic [Gap-1:0] ts);
    @(negedge clk);
    in_bit     = b;
    ctrl_hdb3  = hdb3;
    ctrl_ais   = ais;
    ctrl_tx_en = en;
    in_valid   = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_bit   = 1'b0;
    for (int j = 0; j < Gap; j++) begin
      if (j > 0) @(negedge clk);
      tp[j] = out_p;
      tn[j] = out_n;
      ts[j] = out_sym_stb;
    end
  endtask

  task automatic check_line(input string name, input int line, input logic [Gap-1:0] tp,
                            input logic [Gap-1:0] tn, input logic [Gap-1:0] ts);
    logic [Gap-1:0] ep, eq, es;
    ep = '0;
    eq = '0;
    es = '0;
    es[0] = 1'b1;
    for (int j = 0; j < PulseW; j++) begin
      ep[j] = (line == LPos);
      eq[j] = (line == LNeg);
    end
    check(name, 32'({tp, tn, ts}), 32'({ep, eq, es}));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit hdb3;
    bit ais;
    bit en;
    bit b;
    int line;
  } vec_t;

  initial begin : main
    vec_t tbl[$];
    int exp_line[NumVec];
    logic [Gap-1:0] tp, tn, ts;
    int code, line, pcnt, ncnt, lvl;
    bit b, h, a, e;

    // Line per strobe for one continuous stream: AMI marks, 000V, B00V, zero run, AMI, AIS.
    exp_line = '{0, 0, 0, 0, 1, 2, 1, 2, 1, 2, 1, 0, 0, 0, 1, 2, 1, 2, 0, 0,
                 2, 1, 0, 0, 1, 2, 0, 0, 2, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,
                 0, 2, 1, 0, 0, 2, 1, 2, 1};
    for (int k = 0; k < NumVec; k++) begin
      vec_t v;
      v.hdb3 = !(k < 6 || (k >= 32 && k <= 36));
      v.ais  = (k >= 37);
      v.en   = !(k == 43 || k == 44);
      v.b    = (k <= 6 || k == 11 || k == 12);
      v.line = exp_line[k];
      tbl.push_back(v);
    end

    rst        = 1'b1;
    in_bit     = 1'b0;
    in_valid   = 1'b0;
    ctrl_hdb3  = 1'b0;
    ctrl_ais   = 1'b0;
    ctrl_tx_en = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'({out_p, out_n, out_sym_stb}), 32'd0);
`ifdef E1_TX_HDB3_VCNT_EN
    check("reset_vcnt", 32'(vcnt), 32'd0);
`endif
    rst = 1'b0;

    for (int k = 0; k < NumVec; k++) begin
      strobe(tbl[k].b, tbl[k].hdb3, tbl[k].ais, tbl[k].en, tp, tn, ts);
      check_line($sformatf("vec%0d", k), tbl[k].line, tp, tn, ts);
    end
`ifdef E1_TX_HDB3_VCNT_EN
    check("vcnt_table", 32'(vcnt), 32'd5);
`endif

    // Async reset in the middle of a negative pulse.
    @(negedge clk);
    ctrl_ais   = 1'b1;
    ctrl_tx_en = 1'b1;
    in_valid   = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_pulse", 32'({out_p, out_n}), 32'b01);
    #2;
    rst = 1'b1;
    #1;
    check("rst_clears", 32'({out_p, out_n, out_sym_stb}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst      = 1'b0;
    ctrl_ais = 1'b0;
    model_reset();

    // First mark after reset leaves on the 5th strobe as a positive pulse.
    strobe(1'b1, 1'b0, 1'b0, 1'b1, tp, tn, ts);
    check_line("post_rst_s0", LNone, tp, tn, ts);
    for (int k = 1; k < 4; k++) begin
      strobe(1'b0, 1'b0, 1'b0, 1'b1, tp, tn, ts);
      check_line($sformatf("post_rst_s%0d", k), LNone, tp, tn, ts);
    end
    strobe(1'b0, 1'b0, 1'b0, 1'b1, tp, tn, ts);
    check_line("post_rst_first_mark", LPos, tp, tn, ts);

    lvl = 0;
    for (int k = 0; k < 12; k++) begin
      strobe(1'b0, 1'b0, 1'b0, 1'b1, tp, tn, ts);
      lvl += $countones(tp) + $countones(tn);
    end
    check("ami_zeros_quiet", 32'(lvl), 32'd0);

    // Continuous zeros under HDB3 from reset: B00V train, balanced over strobes 1..64.
    do_reset();
    pcnt = 0;
    ncnt = 0;
    for (int k = 0; k <= 64; k++) begin
      code = model_step(1'b0, 1'b1, 1'b0);
      strobe(1'b0, 1'b1, 1'b0, 1'b1, tp, tn, ts);
      check_line($sformatf("zeros%0d", k), code, tp, tn, ts);
      if (k >= 1) begin
        pcnt += int'(tp[0]);
        ncnt += int'(tn[0]);
      end
    end
    check("dc_balance", 32'(pcnt), 32'(ncnt));
    check("dc_pos_count", 32'(pcnt), 32'd16);
`ifdef E1_TX_HDB3_VCNT_EN
    check("vcnt_zeros", 32'(vcnt), 32'd16);
`endif

    do_reset();
    for (int k = 0; k < 400; k++) begin
      b    = ($urandom_range(0, 2) == 0);
      h    = ($urandom_range(0, 9) != 0);
      a    = ($urandom_range(0, 15) == 0);
      e    = ($urandom_range(0, 7) != 0);
      code = model_step(b, h, a);
      line = e ? code : LNone;
      strobe(b, h, a, e, tp, tn, ts);
      check_line($sformatf("rand%0d", k), line, tp, tn, ts);
    end
`ifdef E1_TX_HDB3_VCNT_EN
    check("vcnt_rand", 32'(vcnt), 32'(m_vcount));
`endif

    check("no_overlap", 32'(overlap), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
